// File: rtl/uart_frame_ctrl_if.sv
// Byte-level link between the UART core and the frame controller.
//   rx_valid  UART -> ctrl  1-cycle pulse, rx_byte holds a received byte
//   rx_byte   UART -> ctrl  received byte
//   rx_error  UART -> ctrl  1-cycle pulse on a framing error
//   tx_start  ctrl -> UART  1-cycle pulse, start sending tx_byte
//   tx_byte   ctrl -> UART  byte to send, held until the transmitter goes idle
//   tx_busy   UART -> ctrl  transmitter busy
// master: the UART core side. slave: the frame controller side.
interface uart_frame_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_error;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_busy;

  modport master (
    output rx_valid, rx_byte, rx_error, tx_busy,
    input  tx_start, tx_byte
  );

  modport slave (
    input  rx_valid, rx_byte, rx_error, tx_busy,
    output tx_start, tx_byte
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// UART frame controller between the byte-level UART core and the compute core.
// Collects a configuration frame into a shadow buffer and commits it to cfg_o in
// one edge, runs the core for RUN_CYCLES clocks, snapshots the core state and
// streams it back MSB byte first over the UART transmit handshake.
//
// Ports:
//   clk          system clock, posedge
//   rst_n        asynchronous active-low reset
//   uart         byte link to the UART core (slave side)
//   cfg_o        committed configuration, frame byte 0 in the top byte
//   cfg_valid_o  1-cycle pulse on the cycle cfg_o updates
//   core_en_o    compute-core step enable
//   state_in_i   core state, sent MSB byte first
//   busy_o       high in every state except RX
//   frame_err_o  1-cycle pulse when a partial or bad frame is discarded
//
// Build option: define UART_FRAME_CKSUM_EN to append an XOR checksum byte to each
// config frame; a mismatch discards the frame and answers with a NAK (8'h15).
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RX         | collecting config bytes, idle timeout armed while idx != 0
// RUN        | core_en high, run down-counter ticking
// SNAP       | core_en low, latch state_in into the snapshot register
// TX_SEND    | wait for transmitter idle, present byte k, pulse tx_start
// TX_WAIT_HI | wait for the transmitter to report busy
// TX_WAIT_LO | wait for the transmitter to finish, then next byte or RX
module uart_frame_ctrl #(
  parameter int CFG_BYTES      = 10,
  parameter int STATE_BYTES    = 4,
  parameter int RUN_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_frame_ctrl_if.slave         uart,
  output logic [CFG_BYTES*8-1:0]   cfg_o,
  output logic                     cfg_valid_o,
  output logic                     core_en_o,
  input  logic [STATE_BYTES*8-1:0] state_in_i,
  output logic                     busy_o,
  output logic                     frame_err_o
);

`ifdef UART_FRAME_CKSUM_EN
  localparam bit CKSUM       = 1'b1;
  localparam int FRAME_BYTES = CFG_BYTES + 1;
`else
  localparam bit CKSUM       = 1'b0;
  localparam int FRAME_BYTES = CFG_BYTES;
`endif

  localparam int IW = $clog2(FRAME_BYTES + 1);
  localparam int KW = $clog2(STATE_BYTES + 1);
  localparam int RW = (RUN_CYCLES > 0) ? $clog2(RUN_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [2:0] S_RX         = 3'd0;
  localparam logic [2:0] S_RUN        = 3'd1;
  localparam logic [2:0] S_SNAP       = 3'd2;
  localparam logic [2:0] S_TX_SEND    = 3'd3;
  localparam logic [2:0] S_TX_WAIT_HI = 3'd4;
  localparam logic [2:0] S_TX_WAIT_LO = 3'd5;

  localparam logic [7:0] NAK = 8'h15;

  logic [2:0]               state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [TW-1:0]            idle_q, idle_d;
  logic [RW-1:0]            run_q, run_d;
  logic [KW-1:0]            k_q, k_d;
  logic [7:0]               shadow_q [CFG_BYTES];
  logic [7:0]               shadow_d [CFG_BYTES];
  logic [7:0]               xor_q, xor_d;
  logic                     nak_q, nak_d;
  logic [CFG_BYTES*8-1:0]   cfg_q, cfg_d;
  logic                     cfg_valid_q, cfg_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     tx_start_q, tx_start_d;
  logic [7:0]               tx_byte_q, tx_byte_d;
  logic [STATE_BYTES*8-1:0] snap_q, snap_d;

  logic [CFG_BYTES*8-1:0]   cfg_cand;
  logic [7:0]               snap_byte;

  // Without a checksum the final config byte is merged straight from the bus so
  // the commit lands on the edge that samples it.
  always_comb begin
    cfg_cand = '0;
    for (int i = 0; i < CFG_BYTES; i++) begin
      cfg_cand[(CFG_BYTES-1-i)*8 +: 8] =
        (!CKSUM && i == CFG_BYTES-1) ? uart.rx_byte : shadow_q[i];
    end
  end

  always_comb begin
    snap_byte = '0;
    for (int j = 0; j < STATE_BYTES; j++) begin
      if (k_q == KW'(j)) snap_byte = snap_q[(STATE_BYTES-1-j)*8 +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    idle_d      = idle_q;
    run_d       = run_q;
    k_d         = k_q;
    shadow_d    = shadow_q;
    xor_d       = xor_q;
    nak_d       = nak_q;
    cfg_d       = cfg_q;
    cfg_valid_d = 1'b0;
    frame_err_d = 1'b0;
    tx_start_d  = 1'b0;
    tx_byte_d   = tx_byte_q;
    snap_d      = snap_q;

    case (state_q)
      S_RX: begin
        if (uart.rx_error) begin
          idx_d       = '0;
          xor_d       = '0;
          frame_err_d = 1'b1;
        end else if (uart.rx_valid) begin
          idle_d = TW'(TIMEOUT_CYCLES - 1);
          if (idx_q == IW'(FRAME_BYTES - 1)) begin
            idx_d = '0;
            xor_d = '0;
            if (!CKSUM || uart.rx_byte == xor_q) begin
              cfg_d       = cfg_cand;
              cfg_valid_d = 1'b1;
              if (RUN_CYCLES == 0) begin
                state_d = S_SNAP;
              end else begin
                run_d   = RW'(RUN_CYCLES - 1);
                state_d = S_RUN;
              end
            end else begin
              frame_err_d = 1'b1;
              nak_d       = 1'b1;
              state_d     = S_TX_SEND;
            end
          end else begin
            for (int i = 0; i < CFG_BYTES; i++) begin
              if (idx_q == IW'(i)) shadow_d[i] = uart.rx_byte;
            end
            idx_d = idx_q + IW'(1);
            xor_d = xor_q ^ uart.rx_byte;
          end
        end else if (TIMEOUT_CYCLES != 0 && idx_q != '0) begin
          // idle_q was loaded with TIMEOUT_CYCLES-1 on the last byte, so this
          // fires on the TIMEOUT_CYCLES-th idle clock.
          if (idle_q == '0) begin
            idx_d       = '0;
            xor_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            idle_d = idle_q - TW'(1);
          end
        end
      end

      S_RUN: begin
        if (run_q == '0) state_d = S_SNAP;
        else             run_d   = run_q - RW'(1);
      end

      S_SNAP: begin
        snap_d  = state_in_i;
        k_d     = '0;
        state_d = S_TX_SEND;
      end

      S_TX_SEND: begin
        if (!uart.tx_busy) begin
          tx_byte_d  = nak_q ? NAK : snap_byte;
          tx_start_d = 1'b1;
          state_d    = S_TX_WAIT_HI;
        end
      end

      S_TX_WAIT_HI: begin
        if (uart.tx_busy) state_d = S_TX_WAIT_LO;
      end

      S_TX_WAIT_LO: begin
        if (!uart.tx_busy) begin
          if (nak_q || k_q == KW'(STATE_BYTES - 1)) begin
            idx_d   = '0;
            k_d     = '0;
            nak_d   = 1'b0;
            state_d = S_RX;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = S_TX_SEND;
          end
        end
      end

      default: state_d = S_RX;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RX;
      idx_q       <= '0;
      idle_q      <= '0;
      run_q       <= '0;
      k_q         <= '0;
      shadow_q    <= '{default: '0};
      xor_q       <= '0;
      nak_q       <= 1'b0;
      cfg_q       <= '0;
      cfg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_byte_q   <= '0;
      snap_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      idle_q      <= idle_d;
      run_q       <= run_d;
      k_q         <= k_d;
      shadow_q    <= shadow_d;
      xor_q       <= xor_d;
      nak_q       <= nak_d;
      cfg_q       <= cfg_d;
      cfg_valid_q <= cfg_valid_d;
      frame_err_q <= frame_err_d;
      tx_start_q  <= tx_start_d;
      tx_byte_q   <= tx_byte_d;
      snap_q      <= snap_d;
    end
  end

  // core_en and busy decode the state register so reset clears them at once.
  assign core_en_o     = (state_q == S_RUN);
  assign busy_o        = (state_q != S_RX);
  assign cfg_o         = cfg_q;
  assign cfg_valid_o   = cfg_valid_q;
  assign frame_err_o   = frame_err_q;
  assign uart.tx_start = tx_start_q;
  assign uart.tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
module tb_uart_frame_ctrl;
  localparam int CFG_BYTES      = 10;
  localparam int STATE_BYTES    = 4;
  localparam int RUN_CYCLES     = 8;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int CW = CFG_BYTES * 8;
  localparam int SW = STATE_BYTES * 8;
  localparam int EV_CFG = 0;
  localparam int EV_ERR = 1;
  localparam int EV_TX  = 2;

  typedef struct {
    int            kind;
    logic [CW-1:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] cfg;
  logic          cfg_valid, core_en, busy, frame_err;
  logic [SW-1:0] state_in;

  uart_frame_ctrl_if uart();

  uart_frame_ctrl #(
    .CFG_BYTES(CFG_BYTES), .STATE_BYTES(STATE_BYTES),
    .RUN_CYCLES(RUN_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart(uart),
    .cfg_o(cfg), .cfg_valid_o(cfg_valid), .core_en_o(core_en),
    .state_in_i(state_in), .busy_o(busy), .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  ev_t           exp_q[$];
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] model_cfg = '0;
  bit            long_busy = 1'b0;

  task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic void push(input int kind, input logic [CW-1:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  // Monitor: pops the scoreboard on every DUT event, checks run length and TX spacing.
  initial begin : monitor
    int  run_len;
    bit  outstanding;
    bit  seen_hi;
    ev_t e;
    run_len = 0; outstanding = 0; seen_hi = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_len = 0; outstanding = 0; seen_hi = 0;
      end else begin
        if (core_en) run_len++;
        else if (run_len != 0) begin
          check("core_en_length", CW'(run_len), CW'(RUN_CYCLES));
          run_len = 0;
        end
        if (cfg_valid || frame_err || uart.tx_start) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_event cfg_valid=%b frame_err=%b tx_start=%b tx_byte=%h expected=none",
                     cfg_valid, frame_err, uart.tx_start, uart.tx_byte);
          end else begin
            e = exp_q.pop_front();
            if (cfg_valid) begin
              check("event_kind_cfg", CW'(e.kind), CW'(EV_CFG));
              check("cfg_value", cfg, e.data);
            end else if (frame_err) begin
              check("event_kind_frame_err", CW'(e.kind), CW'(EV_ERR));
            end else begin
              check("event_kind_tx", CW'(e.kind), CW'(EV_TX));
              check("tx_byte", CW'(uart.tx_byte), e.data);
            end
          end
        end
        if (uart.tx_start) begin
          check("tx_start_without_busy_fall", CW'(outstanding), '0);
          outstanding = 1; seen_hi = 0;
        end else if (outstanding) begin
          if (uart.tx_busy) seen_hi = 1;
          else if (seen_hi) outstanding = 0;
        end
      end
    end
  end

  // UART transmitter model: goes busy shortly after tx_start, for a random time.
  initial begin : tx_model
    uart.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && uart.tx_start) begin
        int hold;
        hold = long_busy ? 500 : int'($urandom_range(1, 12));
        long_busy = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk); #1 uart.tx_busy = 1'b1;
        repeat (hold) @(posedge clk);
        #1 uart.tx_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish expected=finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart.rx_valid = 1'b1;
    uart.rx_byte  = b;
    @(negedge clk);
    uart.rx_valid = 1'b0;
    uart.rx_byte  = 8'($urandom);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 4)) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timed_out"}, CW'(n >= 2000), '0);
    if (n >= 2000) exp_q.delete();
  endtask

  // Reference: a frame commits as the big-endian concatenation of its bytes and
  // returns state_in MSB byte first; a bad checksum yields frame_err plus one NAK.
  task automatic run_frame(input logic [7:0] cb [CFG_BYTES], input logic [SW-1:0] st,
                           input bit bad_ck, input bit abort_in_run);
    logic [CW-1:0] c = '0;
    logic [7:0]    x = '0;
    bit            commit;
    int            n;
    for (int i = 0; i < CFG_BYTES; i++) begin
      c = (c << 8) | CW'(cb[i]);
      x = x ^ cb[i];
    end
`ifdef UART_FRAME_CKSUM_EN
    commit = !bad_ck;
`else
    commit = 1'b1;
`endif
    state_in = st;
    if (commit) begin
      push(EV_CFG, c);
      if (!abort_in_run)
        for (int j = STATE_BYTES - 1; j >= 0; j--) push(EV_TX, CW'(st[j*8 +: 8]));
    end else begin
      push(EV_ERR, '0);
      push(EV_TX, CW'(8'h15));
    end
    for (int i = 0; i < CFG_BYTES; i++) begin
      gap();
      send_byte(cb[i]);
    end
`ifdef UART_FRAME_CKSUM_EN
    gap();
    send_byte(bad_ck ? ((x == 8'h00) ? 8'h01 : 8'h00) : x);
`endif
    if (commit) begin
      check("cfg_valid_latency", CW'(cfg_valid), CW'(1));
      model_cfg = c;
    end else begin
      check("frame_err_on_bad_cksum", CW'(frame_err), CW'(1));
    end
    if (abort_in_run) begin
      n = 0;
      while (!core_en && n < 20) begin @(negedge clk); n++; end
      check("core_en_seen_before_reset", CW'(core_en), CW'(1));
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("reset_core_en", CW'(core_en), '0);
      check("reset_busy", CW'(busy), '0);
      check("reset_cfg", cfg, '0);
      model_cfg = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("reset_no_pending_events", CW'(exp_q.size()), '0);
      exp_q.delete();
    end else begin
      // rx traffic while the controller is busy must be ignored
      uart.rx_valid = 1'b1;
      uart.rx_error = 1'($urandom_range(0, 1));
      @(negedge clk);
      uart.rx_valid = 1'b0;
      uart.rx_error = 1'b0;
      wait_idle("frame");
      check("cfg_after_frame", cfg, model_cfg);
    end
  endtask

  task automatic rand_frame(input bit bad_ck, input bit abort_in_run);
    logic [7:0] fb [CFG_BYTES];
    for (int i = 0; i < CFG_BYTES; i++) fb[i] = 8'($urandom);
    run_frame(fb, SW'($urandom), bad_ck, abort_in_run);
  endtask

  initial begin : stimulus
    logic [7:0] fb [CFG_BYTES];
    uart.rx_valid = 1'b0;
    uart.rx_byte  = '0;
    uart.rx_error = 1'b0;
    state_in      = '0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cfg", cfg, '0);
    check("reset_cfg_valid", CW'(cfg_valid), '0);
    check("reset_core_en", CW'(core_en), '0);
    check("reset_busy", CW'(busy), '0);
    check("reset_frame_err", CW'(frame_err), '0);
    check("reset_tx_start", CW'(uart.tx_start), '0);
    check("reset_tx_byte", CW'(uart.tx_byte), '0);
    rst_n = 1'b1;

    for (int i = 0; i < CFG_BYTES; i++) fb[i] = 8'(i + 1);
    run_frame(fb, 32'hDEADBEEF, 1'b0, 1'b0);
    check("directed_cfg", cfg, 80'h0102030405060708090A);

    // partial frame then idle past the timeout
    for (int i = 0; i < 4; i++) begin gap(); send_byte(8'($urandom)); end
    push(EV_ERR, '0);
    repeat (TIMEOUT_CYCLES - 10) @(negedge clk);
    check("no_early_timeout", CW'(exp_q.size()), CW'(1));
    repeat (20) @(negedge clk);
    check("timeout_fired", CW'(exp_q.size()), '0);
    check("cfg_after_timeout", cfg, model_cfg);
    rand_frame(1'b0, 1'b0);

    // framing error after six bytes
    for (int i = 0; i < 6; i++) begin gap(); send_byte(8'($urandom)); end
    push(EV_ERR, '0);
    @(negedge clk); uart.rx_error = 1'b1;
    @(negedge clk); uart.rx_error = 1'b0;
    check("rx_error_frame_err", CW'(frame_err), CW'(1));
    check("cfg_after_rx_error", cfg, model_cfg);
    rand_frame(1'b0, 1'b0);

    // transmitter held busy for 500 clocks after the first byte
    long_busy = 1'b1;
    rand_frame(1'b0, 1'b0);

`ifdef UART_FRAME_CKSUM_EN
    for (int i = 0; i < CFG_BYTES; i++) fb[i] = 8'(i + 1);
    run_frame(fb, SW'($urandom), 1'b1, 1'b0);
    check("cfg_after_bad_cksum", cfg, model_cfg);
`endif

    for (int f = 0; f < 5; f++) begin
`ifdef UART_FRAME_CKSUM_EN
      rand_frame($urandom_range(0, 2) == 0, 1'b0);
`else
      rand_frame(1'b0, 1'b0);
`endif
    end

    rand_frame(1'b0, 1'b1);
    rand_frame(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
